fcp_credit_scheduler: RTL

//   Upstream per-VC credit scheduler feeding downstream_switch_model_v2.
//   - Tracks the FCP credit limit (FCCL) per VC and the cumulative number of beats sent per VC.
//   - Round-robin arbitrates among VCs whose head packet fits in the remaining credit.
//   - Issues one packet grant at a time to the data mover and waits for its done pulse.

---
 rtl/fcp_credit_scheduler.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fcp_credit_scheduler.sv
// Per-VC credit scheduler: round-robin grant of head packets that fit within
// the downstream FCP credit limit, one outstanding packet at a time.
module fcp_credit_scheduler #(
  parameter int NUM_VC            = 4,
  parameter int VC_WIDTH          = 2,
  parameter int QUEUE_INDEX_WIDTH = 16,
  parameter int STAT_WIDTH        = 32,
  parameter int LEN_WIDTH         = 16,
  parameter int INIT_CREDIT       = 256
) (
  input  logic                          clk,
  input  logic                          sys_rst_n,
  input  logic [NUM_VC-1:0]             s_req,
  input  logic [NUM_VC*LEN_WIDTH-1:0]   s_req_len,
  input  logic                          fcp_valid,
  input  logic [QUEUE_INDEX_WIDTH-1:0]  fcp_vc,
  input  logic [STAT_WIDTH-1:0]         fcp_fccl,
  output logic                          m_grant_valid,
  input  logic                          m_grant_ready,
  output logic [VC_WIDTH-1:0]           m_grant_vc,
  output logic [LEN_WIDTH-1:0]          m_grant_len,
  input  logic                          pkt_done,
  output logic [STAT_WIDTH-1:0]         dbg_stall_count
);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

  state_t                  state_q, state_d;
  logic                    grant_valid_q, grant_valid_d;
  logic [VC_WIDTH-1:0]     grant_vc_q, grant_vc_d;
  logic [LEN_WIDTH-1:0]    grant_len_q, grant_len_d;
  logic [VC_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [STAT_WIDTH-1:0]   stall_q, stall_d;
  logic [STAT_WIDTH-1:0]   fccl_q [NUM_VC];
  logic [STAT_WIDTH-1:0]   fccl_d [NUM_VC];
  logic [STAT_WIDTH-1:0]   tx_cnt_q [NUM_VC];
  logic [STAT_WIDTH-1:0]   tx_cnt_d [NUM_VC];

  logic [LEN_WIDTH-1:0]    len_arr [NUM_VC];
  logic [STAT_WIDTH-1:0]   credit [NUM_VC];
  logic [NUM_VC-1:0]       elig;
  logic [VC_WIDTH-1:0]     win_vc;
  logic                    win_found;
  logic [VC_WIDTH-1:0]     idx;

  // Credit is computed modulo 2^STAT_WIDTH so wrapping counters stay consistent.
  always_comb begin
    for (int i = 0; i < NUM_VC; i++) begin
      len_arr[i] = s_req_len[i*LEN_WIDTH +: LEN_WIDTH];
      credit[i]  = fccl_q[i] - tx_cnt_q[i];
      elig[i]    = s_req[i] && (len_arr[i] != '0) &&
                   (credit[i] >= STAT_WIDTH'(len_arr[i]));
    end
  end

  always_comb begin
    win_vc    = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_VC; k++) begin
      idx = rr_ptr_q + VC_WIDTH'(k);
      if (!win_found && elig[idx]) begin
        win_vc    = idx;
        win_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_vc_d    = grant_vc_q;
    grant_len_d   = grant_len_q;
    rr_ptr_d      = rr_ptr_q;
    stall_d       = stall_q;
    fccl_d        = fccl_q;
    tx_cnt_d      = tx_cnt_q;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_vc_d    = win_vc;
          grant_len_d   = len_arr[win_vc];
          grant_valid_d = 1'b1;
          state_d       = GRANT;
        end else if (|s_req && (stall_q != {STAT_WIDTH{1'b1}})) begin
          stall_d = stall_q + STAT_WIDTH'(1);
        end
      end
      GRANT: begin
        if (m_grant_ready) begin
          tx_cnt_d[grant_vc_q] = tx_cnt_q[grant_vc_q] + STAT_WIDTH'(grant_len_q);
          rr_ptr_d             = grant_vc_q + VC_WIDTH'(1);
          grant_valid_d        = 1'b0;
          state_d              = BUSY;
        end
      end
      BUSY: begin
        if (pkt_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Absolute limit update; lives in its own register so it coexists with a debit.
    if (fcp_valid && (fcp_vc < QUEUE_INDEX_WIDTH'(NUM_VC))) begin
      fccl_d[fcp_vc[VC_WIDTH-1:0]] = fcp_fccl;
    end
  end

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= IDLE;
      grant_valid_q <= 1'b0;
      grant_vc_q    <= '0;
      grant_len_q   <= '0;
      rr_ptr_q      <= '0;
      stall_q       <= '0;
      for (int i = 0; i < NUM_VC; i++) begin
        fccl_q[i]   <= STAT_WIDTH'(INIT_CREDIT);
        tx_cnt_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_vc_q    <= grant_vc_d;
      grant_len_q   <= grant_len_d;
      rr_ptr_q      <= rr_ptr_d;
      stall_q       <= stall_d;
      fccl_q        <= fccl_d;
      tx_cnt_q      <= tx_cnt_d;
    end
  end

  assign m_grant_valid   = grant_valid_q;
  assign m_grant_vc      = grant_vc_q;
  assign m_grant_len     = grant_len_q;
  assign dbg_stall_count = stall_q;

endmodule
